// File: rtl/sram_bus_arbiter_if.sv
// rtl/sram_bus_arbiter_if.sv - requester-side request/response bus of sram_bus_arbiter
// Flat per-port vectors: port i occupies slice i of every packed field.
interface sram_bus_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [4*NUM_REQ-1:0]      req_wstrb;
  logic [ADDR_W*NUM_REQ-1:0] req_addr;
  logic [32*NUM_REQ-1:0]     req_wdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [31:0]               rsp_rdata;

  modport master (
    output req_valid, req_wstrb, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_wstrb, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_bus_arbiter.sv
// rtl/sram_bus_arbiter.sv - N-port arbiter driving BaseRAM/ExtRAM with fixed wait-state accesses
// Optional feature macro ARB_ROUND_ROBIN_EN: round-robin grant instead of lowest-index priority.
module sram_bus_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_W       = 32,
  parameter int BANK_AW      = 20,
  parameter int BANK_SEL_BIT = 22,
  parameter int WAIT_CYCLES  = 1
) (
  input  logic                clk,
  input  logic                resetn,
  sram_bus_arbiter_if.slave   bus,
  output logic                base_en,
  output logic [3:0]          base_we,
  output logic [BANK_AW-1:0]  base_addr,
  output logic [31:0]         base_wdata,
  input  logic [31:0]         base_rdata,
  output logic                ext_en,
  output logic [3:0]          ext_we,
  output logic [BANK_AW-1:0]  ext_addr,
  output logic [31:0]         ext_wdata,
  input  logic [31:0]         ext_rdata,
  output logic                busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  generate
    if (WAIT_CYCLES < 1) begin : g_bad_wait
      $error("sram_bus_arbiter: WAIT_CYCLES must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_ext;
  logic [3:0]         sel_wstrb;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [31:0]        rsp_rdata_q;
  logic [NUM_REQ-1:0] ready_c;

  logic               grant_found;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   cand;
  logic [3:0]         g_wstrb;
  logic [BANK_AW-1:0] g_word;
  logic [0:0]         g_bank;
  logic [31:0]        g_wdata;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0]   rr_ptr;
`endif

  // Winner search: first valid port in search order starting at the priority origin.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      cand = IDX_W'((int'(rr_ptr) + 1 + k) % NUM_REQ);
`else
      cand = IDX_W'(k);
`endif
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign g_wstrb = bus.req_wstrb[int'(grant_idx)*4 +: 4];
  assign g_word  = bus.req_addr[int'(grant_idx)*ADDR_W + 2 +: BANK_AW];
  assign g_bank  = bus.req_addr[int'(grant_idx)*ADDR_W + BANK_SEL_BIT +: 1];
  assign g_wdata = bus.req_wdata[int'(grant_idx)*32 +: 32];

  always_comb begin
    ready_c = '0;
    if (resetn && state == IDLE && grant_found)
      ready_c[grant_idx] = 1'b1;
  end

  assign bus.req_ready = ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      sel_idx     <= '0;
      sel_ext     <= 1'b0;
      sel_wstrb   <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      busy        <= 1'b0;
      base_en     <= 1'b0;
      base_we     <= '0;
      base_addr   <= '0;
      base_wdata  <= '0;
      ext_en      <= 1'b0;
      ext_we      <= '0;
      ext_addr    <= '0;
      ext_wdata   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr      <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_found) begin
            state     <= ACCESS;
            busy      <= 1'b1;
            cnt       <= CNT_W'(WAIT_CYCLES - 1);
            sel_idx   <= grant_idx;
            sel_ext   <= g_bank[0];
            sel_wstrb <= g_wstrb;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr    <= grant_idx;
`endif
            // Only the addressed bank picks up new addr/wdata; the other keeps its old values.
            if (g_bank[0]) begin
              ext_en    <= 1'b1;
              ext_we    <= g_wstrb;
              ext_addr  <= g_word;
              ext_wdata <= g_wdata;
            end else begin
              base_en    <= 1'b1;
              base_we    <= g_wstrb;
              base_addr  <= g_word;
              base_wdata <= g_wdata;
            end
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state       <= RESP;
            base_en     <= 1'b0;
            base_we     <= '0;
            ext_en      <= 1'b0;
            ext_we      <= '0;
            rsp_valid_q <= NUM_REQ'(1) << sel_idx;
            if (sel_wstrb == 4'b0000)
              rsp_rdata_q <= sel_ext ? ext_rdata : base_rdata;
            else
              rsp_rdata_q <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state       <= IDLE;
          busy        <= 1'b0;
          rsp_valid_q <= '0;
          rsp_rdata_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb/tb_sram_bus_arbiter.sv - directed self-checking bench for sram_bus_arbiter
// Three instances: A (2 ports, W=1), B (2 ports, W=3), C (3 ports, W=1).
module tb_sram_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  logic rst_a, rst_b, rst_c;

  sram_bus_arbiter_if #(.NUM_REQ(2), .ADDR_W(32)) bus_a ();
  sram_bus_arbiter_if #(.NUM_REQ(2), .ADDR_W(32)) bus_b ();
  sram_bus_arbiter_if #(.NUM_REQ(3), .ADDR_W(32)) bus_c ();

  logic        a_base_en, a_ext_en, a_busy;
  logic [3:0]  a_base_we, a_ext_we;
  logic [19:0] a_base_addr, a_ext_addr;
  logic [31:0] a_base_wdata, a_ext_wdata, a_base_rdata, a_ext_rdata;

  logic        b_base_en, b_ext_en, b_busy;
  logic [3:0]  b_base_we, b_ext_we;
  logic [19:0] b_base_addr, b_ext_addr;
  logic [31:0] b_base_wdata, b_ext_wdata, b_base_rdata, b_ext_rdata;

  logic        c_base_en, c_ext_en, c_busy;
  logic [3:0]  c_base_we, c_ext_we;
  logic [19:0] c_base_addr, c_ext_addr;
  logic [31:0] c_base_wdata, c_ext_wdata, c_base_rdata, c_ext_rdata;

  sram_bus_arbiter #(.NUM_REQ(2), .WAIT_CYCLES(1)) dut_a (
    .clk(clk), .resetn(rst_a), .bus(bus_a.slave),
    .base_en(a_base_en), .base_we(a_base_we), .base_addr(a_base_addr),
    .base_wdata(a_base_wdata), .base_rdata(a_base_rdata),
    .ext_en(a_ext_en), .ext_we(a_ext_we), .ext_addr(a_ext_addr),
    .ext_wdata(a_ext_wdata), .ext_rdata(a_ext_rdata), .busy(a_busy)
  );

  sram_bus_arbiter #(.NUM_REQ(2), .WAIT_CYCLES(3)) dut_b (
    .clk(clk), .resetn(rst_b), .bus(bus_b.slave),
    .base_en(b_base_en), .base_we(b_base_we), .base_addr(b_base_addr),
    .base_wdata(b_base_wdata), .base_rdata(b_base_rdata),
    .ext_en(b_ext_en), .ext_we(b_ext_we), .ext_addr(b_ext_addr),
    .ext_wdata(b_ext_wdata), .ext_rdata(b_ext_rdata), .busy(b_busy)
  );

  sram_bus_arbiter #(.NUM_REQ(3), .WAIT_CYCLES(1)) dut_c (
    .clk(clk), .resetn(rst_c), .bus(bus_c.slave),
    .base_en(c_base_en), .base_we(c_base_we), .base_addr(c_base_addr),
    .base_wdata(c_base_wdata), .base_rdata(c_base_rdata),
    .ext_en(c_ext_en), .ext_we(c_ext_we), .ext_addr(c_ext_addr),
    .ext_wdata(c_ext_wdata), .ext_rdata(c_ext_rdata), .busy(c_busy)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_g [6];
    int w;
    int pulses;

`ifdef ARB_ROUND_ROBIN_EN
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
`endif

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    bus_a.req_valid = '0; bus_a.req_wstrb = '0; bus_a.req_addr = '0; bus_a.req_wdata = '0;
    bus_b.req_valid = '0; bus_b.req_wstrb = '0; bus_b.req_addr = '0; bus_b.req_wdata = '0;
    bus_c.req_valid = '0; bus_c.req_wstrb = '0; bus_c.req_addr = '0; bus_c.req_wdata = '0;
    a_base_rdata = '0; a_ext_rdata = '0;
    b_base_rdata = '0; b_ext_rdata = '0;
    c_base_rdata = '0; c_ext_rdata = '0;

    // Reset: outputs held at zero even with a request pending.
    bus_a.req_valid = 2'b01;
    #12;
    check("rst_ready",   32'(bus_a.req_ready), 32'h0);
    check("rst_rsp",     32'(bus_a.rsp_valid), 32'h0);
    check("rst_base_en", 32'(a_base_en), 32'h0);
    check("rst_busy",    32'(a_busy), 32'h0);
    bus_a.req_valid = 2'b00;
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

    // 1: port0 read from BaseRAM, W=1.
    @(negedge clk);
    bus_a.req_valid = 2'b01;
    bus_a.req_wstrb[3:0] = 4'b0000;
    bus_a.req_addr[31:0] = 32'h0000_0010;
    a_base_rdata = 32'hDEAD_BEEF;
    #1 check("t1_ready", 32'(bus_a.req_ready), 32'h1);
    @(negedge clk);
    bus_a.req_valid = 2'b00;
    #1;
    check("t1_base_en",   32'(a_base_en), 32'h1);
    check("t1_base_addr", 32'(a_base_addr), 32'h4);
    check("t1_ext_en",    32'(a_ext_en), 32'h0);
    check("t1_busy",      32'(a_busy), 32'h1);
    check("t1_no_rsp",    32'(bus_a.rsp_valid), 32'h0);
    @(negedge clk); #1;
    check("t1_rsp_valid", 32'(bus_a.rsp_valid), 32'h1);
    check("t1_rdata",     bus_a.rsp_rdata, 32'hDEAD_BEEF);
    check("t1_en_off",    32'(a_base_en), 32'h0);
    check("t1_resp_busy", 32'(a_busy), 32'h1);
    @(negedge clk); #1;
    check("t1_idle_busy", 32'(a_busy), 32'h0);
    check("t1_rsp_clr",   32'(bus_a.rsp_valid), 32'h0);

    // 2: port1 partial write to ExtRAM.
    @(negedge clk);
    bus_a.req_valid = 2'b10;
    bus_a.req_wstrb[7:4] = 4'b0011;
    bus_a.req_addr[63:32] = 32'h0040_0008;
    bus_a.req_wdata[63:32] = 32'h1234_5678;
    a_ext_rdata = 32'hAAAA_5555;
    #1 check("t2_ready", 32'(bus_a.req_ready), 32'h2);
    @(negedge clk);
    bus_a.req_valid = 2'b00;
    #1;
    check("t2_ext_en",    32'(a_ext_en), 32'h1);
    check("t2_ext_we",    32'(a_ext_we), 32'h3);
    check("t2_ext_addr",  32'(a_ext_addr), 32'h2);
    check("t2_ext_wdata", a_ext_wdata, 32'h1234_5678);
    check("t2_base_en",   32'(a_base_en), 32'h0);
    check("t2_base_we",   32'(a_base_we), 32'h0);
    check("t2_base_hold", 32'(a_base_addr), 32'h4);
    @(negedge clk); #1;
    check("t2_rsp_valid", 32'(bus_a.rsp_valid), 32'h2);
    check("t2_rdata",     bus_a.rsp_rdata, 32'h0);
    check("t2_we_off",    32'(a_ext_we), 32'h0);
    @(negedge clk);

    // 3: both ports valid for six grants.
    bus_a.req_wstrb = '0;
    bus_a.req_addr[31:0]  = 32'h0000_0100;
    bus_a.req_addr[63:32] = 32'h0000_0200;
    bus_a.req_valid = 2'b11;
    #1;
    for (int g = 0; g < 6; g++) begin
      w = 0;
      while (bus_a.req_ready == 2'b00 && w < 8) begin
        @(negedge clk); #1;
        w++;
      end
      check("t3_grant", 32'(bus_a.req_ready), 32'(exp_g[g]));
      @(posedge clk);
      @(negedge clk); #1;
    end
    bus_a.req_valid = 2'b00;

    // 4: W=3 read from ExtRAM; data sampled on the last ACCESS edge.
    @(negedge clk);
    bus_b.req_valid = 2'b01;
    bus_b.req_addr[31:0] = 32'h0040_0020;
    b_ext_rdata = 32'h0;
    #1 check("t4_ready", 32'(bus_b.req_ready), 32'h1);
    @(negedge clk);
    bus_b.req_valid = 2'b00;
    #1;
    check("t4_en_t1",   32'(b_ext_en), 32'h1);
    check("t4_busy_t1", 32'(b_busy), 32'h1);
    check("t4_addr",    32'(b_ext_addr), 32'h8);
    b_ext_rdata = 32'h1111_1111;
    @(negedge clk); #1;
    check("t4_en_t2", 32'(b_ext_en), 32'h1);
    b_ext_rdata = 32'h2222_2222;
    @(negedge clk); #1;
    check("t4_en_t3",  32'(b_ext_en), 32'h1);
    check("t4_rsp_t3", 32'(bus_b.rsp_valid), 32'h0);
    b_ext_rdata = 32'h3333_3333;
    @(negedge clk); #1;
    check("t4_rsp_t4",  32'(bus_b.rsp_valid), 32'h1);
    check("t4_rdata",   bus_b.rsp_rdata, 32'h3333_3333);
    check("t4_en_t4",   32'(b_ext_en), 32'h0);
    check("t4_busy_t4", 32'(b_busy), 32'h1);
    b_ext_rdata = 32'h4444_4444;
    @(negedge clk); #1;
    check("t4_busy_t5", 32'(b_busy), 32'h0);

    // 5: asynchronous reset during the second ACCESS cycle.
    @(negedge clk);
    bus_b.req_valid = 2'b10;
    bus_b.req_addr[63:32] = 32'h0000_0030;
    #1 check("t5_ready", 32'(bus_b.req_ready), 32'h2);
    @(negedge clk);
    bus_b.req_valid = 2'b00;
    #1 check("t5_en_t1", 32'(b_base_en), 32'h1);
    @(negedge clk); #1;
    check("t5_en_t2", 32'(b_base_en), 32'h1);
    #2 rst_b = 1'b0;
    #1;
    check("t5_rst_en",   32'(b_base_en), 32'h0);
    check("t5_rst_busy", 32'(b_busy), 32'h0);
    check("t5_rst_addr", 32'(b_base_addr), 32'h0);
    check("t5_rst_rsp",  32'(bus_b.rsp_valid), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus_b.rsp_valid != 2'b00) pulses++;
    end
    check("t5_no_rsp", 32'(pulses), 32'h0);
    bus_b.req_valid = 2'b01;
    bus_b.req_addr[31:0] = 32'h0000_0040;
    b_base_rdata = 32'h5A5A_5A5A;
    #1 check("t5_regrant", 32'(bus_b.req_ready), 32'h1);
    @(negedge clk);
    bus_b.req_valid = 2'b00;
    repeat (3) @(negedge clk);
    #1;
    check("t5_rsp",   32'(bus_b.rsp_valid), 32'h1);
    check("t5_rdata", bus_b.rsp_rdata, 32'h5A5A_5A5A);

    // 6: three ports, ports 1 and 2 valid together.
    @(negedge clk);
    bus_c.req_addr[63:32] = 32'h0000_0050;
    bus_c.req_addr[95:64] = 32'h0000_0060;
    bus_c.req_valid = 3'b110;
    #1 check("t6_ready_first", 32'(bus_c.req_ready), 32'h2);
    @(negedge clk);
    bus_c.req_valid = 3'b100;
    #1 check("t6_ready_access", 32'(bus_c.req_ready), 32'h0);
    @(negedge clk); #1;
    check("t6_ready_resp", 32'(bus_c.req_ready), 32'h0);
    check("t6_rsp1",       32'(bus_c.rsp_valid), 32'h2);
    @(negedge clk); #1;
    check("t6_ready_second", 32'(bus_c.req_ready), 32'h4);
    @(negedge clk);
    bus_c.req_valid = 3'b000;
    @(negedge clk); #1;
    check("t6_rsp2", 32'(bus_c.rsp_valid), 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
